// File: rtl/dependancy_pkg.sv
// Shared definitions for the dependency tracking blocks.
//   REG_COUNT      : architectural registers tracked per mask (bit 16 = hidden register)
//   SP_*           : bit positions inside the 3-bit special mask
//   dep_masks_t    : read / write / special masks carried by one instruction
package dependancy_pkg;

    localparam int REG_COUNT = 17;
    localparam int SP_COUNT  = 3;

    localparam int SP_JUMP  = 0;
    localparam int SP_MEMRD = 1;
    localparam int SP_MEMWR = 2;

    typedef struct packed {
        logic [REG_COUNT-1:0] rd;
        logic [REG_COUNT-1:0] wr;
        logic [SP_COUNT-1:0]  sp;
    } dep_masks_t;

endpackage

// File: rtl/first_free_encoder.sv
// Priority encoder that finds the lowest-index free slot.
//   busy      in  N   occupied-slot mask
//   free_idx  out W   lowest index whose busy bit is 0 (0 when none is free)
//   any_free  out 1   at least one slot is free
module first_free_encoder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] busy,
    output logic [W-1:0] free_idx,
    output logic         any_free
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dependancy_scoreboard.sv
// In-flight instruction scoreboard. Accepts a decoded instruction only when it
// has no register or memory/jump hazard against any occupied slot, and frees
// slots when execution retires them by index.
//   main_clk, main_rst_n             clock, asynchronous active-low reset
//   new_valid/new_read/new_write/new_special   candidate instruction and its masks
//   issue_fire, issue_slot           accept strobe and allocated slot (same cycle)
//   retire_valid, retire_slot        free one slot
//   flush                            discard every in-flight slot
//   busy_mask, occupancy, full, empty  slot status
//   retire_error                     sticky: an unoccupied slot was retired
module dependancy_scoreboard
    import dependancy_pkg::*;
#(
    parameter int SLOTS  = 8,
    parameter int SLOT_W = $clog2(SLOTS)
) (
    input  logic                 main_clk,
    input  logic                 main_rst_n,
    input  logic                 new_valid,
    input  logic [REG_COUNT-1:0] new_read,
    input  logic [REG_COUNT-1:0] new_write,
    input  logic [SP_COUNT-1:0]  new_special,
    output logic                 issue_fire,
    output logic [SLOT_W-1:0]    issue_slot,
    input  logic                 retire_valid,
    input  logic [SLOT_W-1:0]    retire_slot,
    input  logic                 flush,
    output logic [SLOTS-1:0]     busy_mask,
    output logic [SLOT_W:0]      occupancy,
    output logic                 full,
    output logic                 empty,
    output logic                 retire_error
);

    localparam int OCC_W = SLOT_W + 1;

    logic [SLOTS-1:0] busy_reg;
    dep_masks_t       masks_reg [SLOTS];
    logic             retire_error_reg;

    dep_masks_t       pend;
    dep_masks_t       new_masks;
    logic [OCC_W-1:0] occ_count;
    logic             any_free;
    logic             hazard;
    logic             jump_blocked;
    logic             mem_blocked;
    logic [SLOTS-1:0] issue_hit;
    logic [SLOTS-1:0] retire_hit;

    assign new_masks = '{rd: new_read, wr: new_write, sp: new_special};

    // Pending aggregates over occupied slots. Freed slots hold zero masks,
    // the busy gate just keeps the aggregate honest independent of that.
    always_comb begin
        pend = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (busy_reg[i]) begin
                pend = dep_masks_t'(pend | masks_reg[i]);
            end
        end
    end

    always_comb begin
        occ_count = '0;
        for (int i = 0; i < SLOTS; i++) begin
            occ_count = occ_count + OCC_W'(busy_reg[i]);
        end
    end

    first_free_encoder #(
        .N (SLOTS),
        .W (SLOT_W)
    ) u_first_free (
        .busy     (busy_reg),
        .free_idx (issue_slot),
        .any_free (any_free)
    );

    // A pending jump blocks everything; a new jump needs an empty scoreboard.
    assign jump_blocked = pend.sp[SP_JUMP]
                        | (new_special[SP_JUMP] & (occ_count != '0));

    // Reads may pass reads, but nothing passes a pending memory write and a
    // memory write may not pass any pending memory access.
    assign mem_blocked  = (new_special[SP_MEMRD] & pend.sp[SP_MEMWR])
                        | (new_special[SP_MEMWR] & (pend.sp[SP_MEMWR] | pend.sp[SP_MEMRD]));

    assign hazard = (|(new_read  & pend.wr))
                  | (|(new_write & pend.rd))
                  | (|(new_write & pend.wr))
                  | jump_blocked
                  | mem_blocked;

    // Gated by reset so nothing is accepted while the scoreboard is held clear.
    assign issue_fire = main_rst_n & new_valid & ~hazard & any_free & ~flush;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot_sel
            assign issue_hit[gi]  = issue_fire   && (issue_slot  == SLOT_W'(gi));
            assign retire_hit[gi] = retire_valid && (retire_slot == SLOT_W'(gi));
        end
    endgenerate

    // Issue and retire never collide: the issue slot is always a free one.
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            busy_reg <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                masks_reg[i] <= '0;
            end
        end else if (flush) begin
            busy_reg <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                masks_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (issue_hit[i]) begin
                    busy_reg[i]  <= 1'b1;
                    masks_reg[i] <= new_masks;
                end else if (retire_hit[i] && busy_reg[i]) begin
                    busy_reg[i]  <= 1'b0;
                    masks_reg[i] <= '0;
                end
            end
        end
    end

    // Sticky until reset; a retire swallowed by a flush is not an error.
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            retire_error_reg <= 1'b0;
        end else if (retire_valid && !flush && !busy_reg[retire_slot]) begin
            retire_error_reg <= 1'b1;
        end
    end

    assign busy_mask    = busy_reg;
    assign occupancy    = occ_count;
    assign full         = (occ_count == OCC_W'(SLOTS));
    assign empty        = (occ_count == '0);
    assign retire_error = retire_error_reg;

endmodule
